// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the 8-bit / 64 KB synchronous memory bus.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention (default: m1 priority).
module mem_bus_arbiter #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clock_25,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    input  logic        m0_wr,
    output logic        m0_ack,
    output logic [7:0]  m0_rdata,
    input  logic        m1_req,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    input  logic        m1_wr,
    output logic        m1_ack,
    output logic [7:0]  m1_rdata,
    input  logic [7:0]  i_data,
    output logic [15:0] o_addr,
    output logic [7:0]  o_data,
    output logic        o_wr,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_DATA
    } state_t;

    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        owr_q, owr_d;
    logic        wr_q, wr_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [7:0]  rd0_q, rd0_d;
    logic [7:0]  rd1_q, rd1_d;
    logic        busy_q, busy_d;
    logic        own_q, own_d;
    logic [3:0]  wcnt_q, wcnt_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic        last_q, last_d;
`endif

    logic elig0, elig1, grant1;

    // A master being acked this cycle is not eligible, so a held req is not regranted
    assign elig0 = m0_req & ~ack0_q;
    assign elig1 = m1_req & ~ack1_q;

    always_comb begin
        grant1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        grant1 = elig1 & (~elig0 | ~last_q);
`else
        grant1 = elig1;
`endif
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        owr_d   = 1'b0;
        wr_d    = wr_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        busy_d  = busy_q;
        own_d   = own_q;
        wcnt_d  = wcnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (elig0 | elig1) begin
                    own_d   = grant1;
                    addr_d  = grant1 ? m1_addr : m0_addr;
                    data_d  = grant1 ? m1_wdata : m0_wdata;
                    wr_d    = grant1 ? m1_wr : m0_wr;
                    owr_d   = grant1 ? m1_wr : m0_wr;
                    busy_d  = 1'b1;
                    state_d = S_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = grant1;
`endif
                end
            end
            S_ADDR: begin
                if (WAIT_STATES > 0) begin
                    wcnt_d  = WS_LOAD;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_DATA: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (own_q) begin
                    ack1_d = 1'b1;
                    if (!wr_q) rd1_d = i_data;
                end else begin
                    ack0_d = 1'b1;
                    if (!wr_q) rd0_d = i_data;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            owr_q   <= 1'b0;
            wr_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            busy_q  <= 1'b0;
            own_q   <= 1'b0;
            wcnt_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            owr_q   <= owr_d;
            wr_q    <= wr_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            busy_q  <= busy_d;
            own_q   <= own_d;
            wcnt_q  <= wcnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign o_addr   = addr_q;
    assign o_data   = data_q;
    assign o_wr     = owr_q;
    assign m0_ack   = ack0_q;
    assign m1_ack   = ack1_q;
    assign m0_rdata = rd0_q;
    assign m1_rdata = rd1_q;
    assign busy     = busy_q;
    assign owner    = own_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit / 64 KB memory bus of the demo system between two requesters: m0 (CPU core) and m1 (video/DMA fetch).
- Arbitrates, drives the shared bus (o_addr, o_data, o_wr, i_data) through a fixed access sequence, and returns read data with a one-cycle ack pulse.
- Sits between the processor core and the synchronous memory (1-cycle read latency) and is clocked by the 25 MHz system clock.

Parameters:
- WAIT_STATES, 0, extra bus cycles inserted between address phase and data capture; legal range 0..15.

Ports:
- clock_25  in  1  system clock, 25 MHz, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  CPU request; held high with address and data stable until m0_ack.
- m0_addr  in  16  CPU address.
- m0_wdata  in  8  CPU write data.
- m0_wr  in  1  1 = write, 0 = read.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  8  read data; valid while m0_ack is high, held afterwards.
- m1_req, m1_addr, m1_wdata, m1_wr, m1_ack, m1_rdata: same as m0, for the video/DMA requester.
- i_data  in  8  memory read data.
- o_addr  out  16  memory address.
- o_data  out  8  memory write data.
- o_wr  out  1  memory write strobe.
- busy  out  1  high while a transaction is in progress.
- owner  out  1  master of the current or most recent grant (0 = m0, 1 = m1).

Behaviour:
- Reset (async, active-high): state to IDLE; o_addr = 0, o_data = 0, o_wr = 0, m0/m1_ack = 0, m0/m1_rdata = 0, busy = 0, owner = 0, WAIT counter = 0, round-robin last-grant = m0. The effect is immediate, without waiting for a clock edge.
- All outputs are registered.
- States: IDLE -> ADDR -> WAIT (WAIT_STATES cycles; skipped if 0) -> DATA -> IDLE.
- IDLE:
  - Evaluates requests.
  - A master whose ack is high in this cycle is excluded, so a held req is not regranted.
  - If an eligible request exists, at the edge: latch the winner's addr, wdata and wr into o_addr, o_data and the write flag; set owner; go to ADDR.
  - With no eligible request, the bus registers hold their values.
- ADDR:
  - Bus is driven.
  - o_wr = 1 for exactly this one cycle if the transfer is a write; memory commits at the edge ending ADDR.
  - Next state is WAIT if WAIT_STATES > 0, else DATA.
- WAIT: counter loaded with WAIT_STATES-1 on entry and decremented each cycle; leave for DATA when it reaches 0.
- DATA:
  - i_data is valid.
  - At the edge ending DATA, for a read, the owner's rdata <= i_data; writes leave rdata unchanged.
  - The owner's ack <= 1 for one cycle (the following IDLE cycle), for reads and writes.
- Latency: with the request sampled at edge E, ack is high in cycle WAIT_STATES+3 after E. Throughput is one transfer per WAIT_STATES+3 cycles.
- The ack cycle is an IDLE cycle, so the other master can be granted in that same cycle, back-to-back with no bubble.
- busy = 1 in ADDR, WAIT and DATA; 0 in IDLE.
- Arbitration (default build): fixed priority, m1 wins over m0 when both are eligible.
- Requester changing addr/wdata/wr while req is high: ignored after the IDLE latch. Changing them before ack is a protocol violation with undefined effect on that requester's data only.
- Reset mid-transaction:
  - The transaction is aborted and no ack is issued.
  - If reset hits during ADDR, o_wr drops immediately and the write is not guaranteed.
  - After release, IDLE accepts requests normally.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both masters are eligible in IDLE, grant the master not granted last; the last-grant register updates on every grant. The first contended grant after reset goes to m1. An uncontended request is granted immediately, as in the default build.
- Undefined: fixed m1-over-m0 priority, no last-grant register.

Test Plan:
- Reset: assert reset mid-stream -> all outputs 0 with no clock edge needed; busy = 0, owner = 0.
- Read, WAIT_STATES = 0: m0 reads 0x1234, memory holds 0xA5 -> o_addr = 0x1234 from the ADDR cycle, o_wr stays 0, m0_ack high in the 3rd cycle after sampling, m0_rdata = 0xA5, m1_ack = 0.
- Write: m0 writes 0x3C to 0x0200 -> o_wr high exactly 1 cycle with o_addr = 0x0200 and o_data = 0x3C; memory[0x0200] = 0x3C; single m0_ack pulse; m0_rdata unchanged.
- Contention, default build: m0 and m1 reads raised in the same cycle and held until ack -> m1 acked first, m0 granted in m1's ack cycle, m0 acked 3 cycles later. With ARB_ROUND_ROBIN_EN and both requests re-raised continuously -> grants alternate m1, m0, m1, m0.
- WAIT_STATES = 2: m1 reads 0x8000 holding 0x5A -> busy high 4 cycles, m1_ack in the 5th cycle after sampling, m1_rdata = 0x5A.
- Reset during WAIT (WAIT_STATES = 3): no ack, busy drops immediately. A subsequent m0 read of 0x0010 completes normally with the correct data.
